// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - time-multiplexed hex digit scan controller with framed updates
module hex_scan_ctrl #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD_CYC  = 2,
  parameter int AN_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   upd_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic                  lz_en,
  output logic [3:0]            hex_in,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic          ACT_LOW = (AN_ACT_LOW != 0);

  typedef enum logic {GUARD, DRIVE} st_t;

  logic [4*DIGITS-1:0] disp, pend, disp_n;
  logic                pend_full;
  logic [IW-1:0]       idx, idx_n;
  logic [CW-1:0]       cnt, cnt_n;
  st_t                 st, st_n;
  logic                wrap, boundary, xfer;
  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   an_on;
  logic [3:0]          hex_n;
  logic                zero_hi;

  assign upd_ready = !pend_full;
  assign xfer      = upd_valid && !pend_full;

  // Slot/digit sequencing, slot state transitions and frame-boundary display swap.
  always_comb begin
    wrap     = (cnt == CNT_MAX);
    boundary = wrap && (idx == IDX_MAX);
    cnt_n    = wrap ? '0 : cnt + 1'b1;
    idx_n    = idx;
    if (wrap) idx_n = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    st_n = st;
    case (st)
      GUARD:   if (cnt_n == CNT_GRD) st_n = DRIVE;
      DRIVE:   if (wrap) st_n = GUARD;
      default: st_n = GUARD;
    endcase
    disp_n = (boundary && pend_full) ? pend : disp;
  end

  // Leading-zero map: digit i>0 is blank-able when it and every higher nibble are zero.
  always_comb begin
    supp    = '0;
    zero_hi = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi && (disp_n[4*i +: 4] == 4'h0);
      supp[i] = (i != 0) && zero_hi;
    end
  end

  // Output values for the cycle being entered; registered below so outputs track the slot state.
  always_comb begin
    hex_n = disp_n[4*int'(idx_n) +: 4];
    an_on = '0;
    if (st_n == DRIVE && !(lz_en && supp[idx_n]))
      an_on = DIGITS'(1) << idx_n;
  end

  // State, handshake buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      st         <= GUARD;
      hex_in     <= 4'h0;
      an         <= {DIGITS{ACT_LOW}};
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      st         <= st_n;
      disp       <= disp_n;
      if (xfer) pend <= upd_data;
      pend_full  <= xfer ? 1'b1 : (boundary ? 1'b0 : pend_full);
      hex_in     <= hex_n;
      an         <= an_on ^ {DIGITS{ACT_LOW}};
      frame_done <= boundary;
    end
  end

endmodule
